// File: rtl/mainfsm_hs.sv
// mainfsm_hs: multicycle main controller with memory ready and FPU start/done handshakes plus FPU timeout fault
module mainfsm_hs #(
  parameter int MEM_HS = 1,
  parameter int FPU_HS = 1,
  parameter int FPU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  input  logic       FPUDone,
  output logic       NextPC,
  output logic       Branch,
  output logic       MemW,
  output logic       RegW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       FPUW,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       MemReq,
  output logic       FPUStart,
  output logic       Fault,
  output logic [3:0] State
);
  localparam int CW = $clog2(FPU_TIMEOUT + 1);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    FPUEXEC = 4'd11, FPUWAIT = 4'd12, FPUWB = 4'd13, FAULT = 4'd14
  } state_t;
  state_t st, nx;
  logic [CW-1:0] cnt;
  logic rdy;
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
  assign rdy = (MEM_HS != 0) ? MemReady : 1'b1;
  always_comb begin
    nx = FAULT;
    case (st)
      FETCH:    nx = rdy ? DECODE : FETCH;
      DECODE:   nx = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                     Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : FPUEXEC;
      EXECUTER: nx = ALUWB;
      EXECUTEI: nx = ALUWB;
      ALUWB:    nx = FETCH;
      MEMADR:   nx = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    nx = rdy ? MEMWB : MEMRD;
      MEMWR:    nx = rdy ? FETCH : MEMWR;
      MEMWB:    nx = FETCH;
      BRANCH:   nx = FETCH;
      FPUEXEC:  nx = (FPU_HS != 0) ? FPUWAIT : FPUWB;
      FPUWAIT:  nx = FPUDone ? FPUWB : cnt == CW'(FPU_TIMEOUT - 1) ? FAULT : FPUWAIT;
      FPUWB:    nx = FETCH;
      default:  nx = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nx;
      cnt <= st == FPUEXEC ? '0 : st == FPUWAIT ? cnt + 1'b1 : cnt;
    end
  end
  assign NextPC    = st == FETCH && rdy;
  assign IRWrite   = st == FETCH && rdy;
  assign Branch    = st == BRANCH;
  assign MemW      = st == MEMWR;
  assign RegW      = st == ALUWB || st == MEMWB || st == FPUWB;
  assign AdrSrc    = st == MEMRD || st == MEMWR;
  assign FPUW      = st == FPUWB;
  assign ALUOp     = st == EXECUTER || st == EXECUTEI;
  assign ResultSrc = (st == FETCH || st == DECODE || st == BRANCH) ? 2'b10 : st == MEMWB ? 2'b01 : 2'b00;
  assign ALUSrcA   = (st == FETCH || st == DECODE) ? 2'b01 : st == FPUWB ? 2'b10 : 2'b00;
  assign ALUSrcB   = (st == FETCH || st == DECODE) ? 2'b10 :
                     (st == EXECUTEI || st == MEMADR || st == BRANCH) ? 2'b01 : 2'b00;
  assign MemReq    = st == FETCH || st == MEMRD || st == MEMWR;
  assign FPUStart  = st == FPUEXEC;
  assign Fault     = st == FAULT;
  assign State     = st;
endmodule

// File: tb/tb_mainfsm_hs.sv
// tb_mainfsm_hs: scoreboard bench for mainfsm_hs across handshake/timeout configurations
module tb_mainfsm_hs;
  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MRD = 4'd3, MWB = 4'd4, MWR = 4'd5,
                         XR = 4'd6, XI = 4'd7, AW = 4'd8, BR = 4'd9, FX = 4'd11, FW = 4'd12,
                         FB = 4'd13, FT = 4'd14;
  localparam int NPC = 16, BRA = 15, MW = 14, RW = 13, IRW = 12, ADR = 11, FPW = 10, AOP = 9,
                 RS = 7, SA = 5, SB = 3, MRQ = 2, FST = 1, FLT = 0;
  typedef struct {
    string       tag;
    int          inst;
    logic [3:0]  st;
    logic [16:0] cw;
  } exp_t;
  logic clk = 0, reset = 0, mem_ready = 0, fpu_done = 0;
  logic [1:0] op = 0;
  logic [5:0] funct = 0;
  logic [16:0] cw [3];
  logic [3:0] st [3];
  exp_t sb [$];
  int checks = 0, errors = 0, n = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mainfsm_hs #(.MEM_HS(g == 2 ? 0 : 1), .FPU_HS(g == 2 ? 0 : 1), .FPU_TIMEOUT(g == 1 ? 4 : 16)) u (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mem_ready), .FPUDone(fpu_done),
      .NextPC(cw[g][16]), .Branch(cw[g][15]), .MemW(cw[g][14]), .RegW(cw[g][13]),
      .IRWrite(cw[g][12]), .AdrSrc(cw[g][11]), .FPUW(cw[g][10]), .ALUOp(cw[g][9]),
      .ResultSrc(cw[g][8:7]), .ALUSrcA(cw[g][6:5]), .ALUSrcB(cw[g][4:3]),
      .MemReq(cw[g][2]), .FPUStart(cw[g][1]), .Fault(cw[g][0]), .State(st[g])
    );
  end
  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [3:0] s, input logic rdy);
    logic [16:0] w;
    w = '0;
    case (s)
      F: begin w[NPC] = rdy; w[IRW] = rdy; w[RS+:2] = 2'b10; w[SA+:2] = 2'b01; w[SB+:2] = 2'b10; w[MRQ] = 1; end
      D: begin w[RS+:2] = 2'b10; w[SA+:2] = 2'b01; w[SB+:2] = 2'b10; end
      MA: w[SB+:2] = 2'b01;
      MRD: begin w[ADR] = 1; w[MRQ] = 1; end
      MWB: begin w[RW] = 1; w[RS+:2] = 2'b01; end
      MWR: begin w[MW] = 1; w[ADR] = 1; w[MRQ] = 1; end
      XR: w[AOP] = 1;
      XI: begin w[AOP] = 1; w[SB+:2] = 2'b01; end
      AW: w[RW] = 1;
      BR: begin w[BRA] = 1; w[RS+:2] = 2'b10; w[SB+:2] = 2'b01; end
      FX: w[FST] = 1;
      FB: begin w[RW] = 1; w[FPW] = 1; w[SA+:2] = 2'b10; end
      FT: w[FLT] = 1;
      default: w = '0;
    endcase
    return w;
  endfunction
  task automatic cyc(input string tag, input int inst, input logic [3:0] es,
                     input logic mr = 1'b1, input logic fd = 1'b0);
    exp_t e;
    mem_ready = mr;
    fpu_done = fd;
    e.tag = $sformatf("%s.%0d", tag, n);
    e.inst = inst;
    e.st = es;
    e.cw = model(es, inst == 2 ? 1'b1 : mr);
    n++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic rst;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  task automatic ins(input logic [1:0] o, input logic [5:0] f);
    op = o;
    funct = f;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, " state"}, 17'(st[e.inst]), 17'(e.st));
      chk({e.tag, " ctl"}, cw[e.inst], e.cw);
    end
  end
  initial begin
    #1;
    rst;
    ins(2'b00, 6'b000100);
    cyc("add", 0, F); cyc("add", 0, D); cyc("add", 0, XR); cyc("add", 0, AW); cyc("add", 0, F);
    rst;
    ins(2'b01, 6'b000001);
    cyc("ldr", 0, F); cyc("ldr", 0, D); cyc("ldr", 0, MA);
    cyc("ldr", 0, MRD, 0); cyc("ldr", 0, MRD, 0); cyc("ldr", 0, MRD, 1);
    cyc("ldr", 0, MWB); cyc("ldr", 0, F);
    rst;
    ins(2'b01, 6'b000000);
    cyc("str", 0, F, 0); cyc("str", 0, F, 0); cyc("str", 0, F, 0); cyc("str", 0, F, 1);
    cyc("str", 0, D, 0); cyc("str", 0, MA, 0);
    cyc("str", 0, MWR, 0); cyc("str", 0, MWR, 0); cyc("str", 0, MWR, 1); cyc("str", 0, F);
    rst;
    ins(2'b10, 6'b000000);
    cyc("b", 0, F); cyc("b", 0, D); cyc("b", 0, BR); cyc("b", 0, F);
    rst;
    ins(2'b00, 6'b100000);
    cyc("addi", 0, F); cyc("addi", 0, D, 1, 1); cyc("addi", 0, XI); cyc("addi", 0, AW); cyc("addi", 0, F);
    rst;
    ins(2'b11, 6'b000000);
    cyc("fpu", 0, F); cyc("fpu", 0, D); cyc("fpu", 0, FX);
    for (int i = 0; i < 4; i++) cyc("fpu", 0, FW);
    cyc("fpu", 0, FW, 1, 1); cyc("fpu", 0, FB); cyc("fpu", 0, F);
    rst;
    cyc("tmo", 1, F); cyc("tmo", 1, D); cyc("tmo", 1, FX);
    for (int i = 0; i < 4; i++) cyc("tmo", 1, FW);
    cyc("tmo", 1, FT); cyc("tmo", 1, FT, 1, 1); cyc("tmo", 1, FT);
    rst;
    cyc("tmo_rst", 1, F, 0);
    cyc("win", 1, F); cyc("win", 1, D); cyc("win", 1, FX);
    for (int i = 0; i < 3; i++) cyc("win", 1, FW);
    cyc("win", 1, FW, 1, 1); cyc("win", 1, FB); cyc("win", 1, F);
    rst;
    ins(2'b01, 6'b000000);
    cyc("mwr_rst", 0, F); cyc("mwr_rst", 0, D); cyc("mwr_rst", 0, MA);
    cyc("mwr_rst", 0, MWR, 0); cyc("mwr_rst", 0, MWR, 0);
    rst;
    cyc("mwr_rst", 0, F, 0);
    rst;
    ins(2'b11, 6'b000000);
    cyc("nohs", 2, F, 0); cyc("nohs", 2, D, 0); cyc("nohs", 2, FX, 0); cyc("nohs", 2, FB, 0); cyc("nohs", 2, F, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", 17'(sb.size()), 17'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
